uart_tx_sched: RTL

Transmit scheduler that sits in front of the `UART_tx` serializer and shares it between two requesters: a single-byte command acknowledge and a two-byte position telemetry record. It latches requests as pending flags, arbitrates round-robin when both are pending, and issues one-cycle `trmt` pulses with the correct `tx_data`. It then paces the next byte on the serializer's `tx_done` rising edge. It counts telemetry samples that are overwritten before they are sent.

---
 rtl/uart_tx_sched_if.sv | 9 +
 rtl/uart_tx_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - scheduler to UART_tx serializer link
interface uart_tx_sched_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (output trmt, output tx_data, input tx_done);
    modport slave  (input trmt, input tx_data, output tx_done);
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin ACK/telemetry scheduler in front of UART_tx
module uart_tx_sched #(
    parameter logic [7:0] ACK_BYTE = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ack_req,
    input  logic                    tlm_req,
    input  logic [15:0]             tlm_data,
    output logic                    busy,
    output logic [7:0]              tlm_ovr,
    uart_tx_sched_if.master         ser
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    localparam logic G_ACK = 1'b0;
    localparam logic G_TLM = 1'b1;

    state_t      state_q, state_d;
    logic        ack_pend_q, ack_pend_d;
    logic        tlm_pend_q, tlm_pend_d;
    logic [15:0] tlm_word_q, tlm_word_d;
    logic [15:0] send_q, send_d;
    logic        lsb_left_q, lsb_left_d;
    logic        last_grant_q, last_grant_d;
    logic        trmt_q, trmt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic [7:0]  tlm_ovr_q, tlm_ovr_d;
    logic        tx_done_q;
    logic        grant_ack, grant_tlm;
    logic        done_rise;

    assign done_rise   = ser.tx_done & ~tx_done_q;
    assign ser.trmt    = trmt_q;
    assign ser.tx_data = tx_data_q;
    assign busy        = busy_q;
    assign tlm_ovr     = tlm_ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ack_pend_q   <= 1'b0;
            tlm_pend_q   <= 1'b0;
            tlm_word_q   <= 16'h0000;
            send_q       <= 16'h0000;
            lsb_left_q   <= 1'b0;
            last_grant_q <= G_TLM;
            trmt_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            tlm_ovr_q    <= 8'h00;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_pend_q   <= ack_pend_d;
            tlm_pend_q   <= tlm_pend_d;
            tlm_word_q   <= tlm_word_d;
            send_q       <= send_d;
            lsb_left_q   <= lsb_left_d;
            last_grant_q <= last_grant_d;
            trmt_q       <= trmt_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            tlm_ovr_q    <= tlm_ovr_d;
            tx_done_q    <= ser.tx_done;
        end
    end

    always_comb begin
        state_d      = state_q;
        ack_pend_d   = ack_pend_q;
        tlm_pend_d   = tlm_pend_q;
        tlm_word_d   = tlm_word_q;
        send_d       = send_q;
        lsb_left_d   = lsb_left_q;
        last_grant_d = last_grant_q;
        tx_data_d    = tx_data_q;
        tlm_ovr_d    = tlm_ovr_q;
        grant_ack    = 1'b0;
        grant_tlm    = 1'b0;

        case (state_q)
            IDLE: begin
                // last_grant only tracks contended arbitrations, so alternation is between ties
                if (ack_pend_q && tlm_pend_q) begin
                    if (last_grant_q == G_TLM) begin
                        grant_ack    = 1'b1;
                        last_grant_d = G_ACK;
                    end else begin
                        grant_tlm    = 1'b1;
                        last_grant_d = G_TLM;
                    end
                end else if (ack_pend_q) begin
                    grant_ack = 1'b1;
                end else if (tlm_pend_q) begin
                    grant_tlm = 1'b1;
                end

                if (grant_ack) begin
                    tx_data_d  = ACK_BYTE;
                    ack_pend_d = 1'b0;
                    lsb_left_d = 1'b0;
                    state_d    = LOAD;
                end else if (grant_tlm) begin
                    send_d     = tlm_word_q;
                    tx_data_d  = tlm_word_q[15:8];
                    tlm_pend_d = 1'b0;
                    lsb_left_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: state_d = WAIT;
            WAIT: begin
                if (done_rise) begin
                    if (lsb_left_q) begin
                        tx_data_d  = send_q[7:0];
                        lsb_left_d = 1'b0;
                        state_d    = LOAD;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests are applied after the grant so a same-edge set beats the clear.
        if (ack_req) begin
            ack_pend_d = 1'b1;
        end
        if (tlm_req) begin
            tlm_word_d = tlm_data;
            tlm_pend_d = 1'b1;
            if (tlm_pend_q && !grant_tlm && (tlm_ovr_q != 8'hFF)) begin
                tlm_ovr_d = tlm_ovr_q + 8'd1;
            end
        end
    end

    assign trmt_d = (state_d == LOAD);
    assign busy_d = (state_d != IDLE);

endmodule
